// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps the PC, runs a single-outstanding-request handshake to instruction
// memory, and hands fetched instructions to ID. A branch redirect from EXE
// flushes IF/ID and cancels any fetch in flight; a hazard freeze holds IF/ID
// and the PC, parking an arriving response in a one-entry hold buffer.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding; issue a fetch at pc unless redirected
// WAIT  | one request outstanding; pc is its address
// HOLD  | response parked in hold buffer while ID is frozen
// DROP  | outstanding response belongs to a cancelled fetch; discard it

module fetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [INST_W-1:0] if_id_inst,
   output logic              if_id_valid
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [INST_W-1:0] hold_inst_q, hold_inst_d;
   logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
   logic [INST_W-1:0] if_id_inst_q, if_id_inst_d;
   logic              if_id_valid_q, if_id_valid_d;

   logic [ADDR_W-1:0] pc_plus4;
   logic              req_c;
   logic [ADDR_W-1:0] addr_c;
   logic              deliver;
   logic [INST_W-1:0] deliver_inst;

   // Sequential address; wraps naturally modulo 2^ADDR_W.
   assign pc_plus4 = pc_q + PC_STEP;

   // Fetch sequencing: next state, next pc, hold buffer, request and delivery.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_inst_d  = hold_inst_q;
      req_c        = 1'b0;
      addr_c       = pc_q;
      deliver      = 1'b0;
      deliver_inst = hold_inst_q;
      unique case (state_q)
         S_IDLE: begin
            if (branch_taken) begin
               pc_d = branch_addr;
            end else begin
               req_c   = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (branch_taken) begin
               // Response in the same cycle is simply discarded; otherwise
               // it is still owed to us and must be swallowed in DROP.
               pc_d    = branch_addr;
               state_d = imem_rvalid ? S_IDLE : S_DROP;
            end else if (imem_rvalid) begin
               if (freeze) begin
                  hold_inst_d = imem_rdata;
                  state_d     = S_HOLD;
               end else begin
                  // Deliver and immediately issue the next sequential fetch
                  // so a 1-cycle memory sustains one instruction per cycle.
                  deliver      = 1'b1;
                  deliver_inst = imem_rdata;
                  pc_d         = pc_plus4;
                  req_c        = 1'b1;
                  addr_c       = pc_plus4;
               end
            end
         end
         S_HOLD: begin
            if (branch_taken) begin
               pc_d        = branch_addr;
               hold_inst_d = '0;
               state_d     = S_IDLE;
            end else if (!freeze) begin
               deliver      = 1'b1;
               deliver_inst = hold_inst_q;
               pc_d         = pc_plus4;
               hold_inst_d  = '0;
               state_d      = S_IDLE;
            end
         end
         S_DROP: begin
            if (branch_taken) begin
               pc_d = branch_addr;
            end
            if (imem_rvalid) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // IF/ID next value: flush beats freeze, freeze beats delivery, else bubble.
   always_comb begin
      if_id_valid_d = 1'b0;
      if_id_inst_d  = '0;
      if_id_pc_d    = '0;
      if (branch_taken) begin
         if_id_valid_d = 1'b0;
      end else if (freeze) begin
         if_id_valid_d = if_id_valid_q;
         if_id_inst_d  = if_id_inst_q;
         if_id_pc_d    = if_id_pc_q;
      end else if (deliver) begin
         if_id_valid_d = 1'b1;
         if_id_inst_d  = deliver_inst;
         if_id_pc_d    = pc_plus4;
      end
   end

   // State, pc, hold buffer and IF/ID registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         hold_inst_q   <= '0;
         if_id_pc_q    <= '0;
         if_id_inst_q  <= '0;
         if_id_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         hold_inst_q   <= hold_inst_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   // Request outputs are forced low while reset is asserted.
   assign imem_req    = req_c & rst;
   assign imem_addr   = rst ? addr_c : '0;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_inst  = if_id_inst_q;
   assign if_id_valid = if_id_valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Holds the PC and drives a single-outstanding-request instruction-memory handshake.
- Delivers fetched instructions to the ID stage.
- Consumes the hazard unit's Hazard output as `freeze`, and consumes the EXE branch redirect as a flush.

Parameters:
- ADDR_W, 32, PC / memory address width.
- INST_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- freeze  input  1  hazard stall from hazard detection; IF/ID and PC hold.
- branch_taken  input  1  redirect from EXE; flushes IF/ID and any in-flight fetch.
- branch_addr  input  ADDR_W  redirect target.
- imem_req  output  1  one-cycle fetch request (combinational).
- imem_addr  output  ADDR_W  fetch address, valid when imem_req=1.
- imem_rvalid  input  1  memory response strobe; exactly one per accepted request, at least 1 cycle later.
- imem_rdata  input  INST_W  instruction, valid with imem_rvalid.
- if_id_pc  output  ADDR_W  fetch address + 4 of the held instruction.
- if_id_inst  output  INST_W  held instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=IDLE, hold buffer=0, if_id_pc=0, if_id_inst=0, if_id_valid=0.
- imem_req is 0 whenever rst=0.
- States: IDLE (no request outstanding), WAIT (request outstanding), HOLD (response buffered, ID frozen), DROP (outstanding response to be discarded).

IDLE:
- branch_taken=1: pc<=branch_addr, no request, stay IDLE.
- otherwise: imem_req=1, imem_addr=pc, go WAIT.

WAIT, rows in priority order:
- branch_taken=1 and imem_rvalid=1: discard data, pc<=branch_addr, go IDLE.
- branch_taken=1 and imem_rvalid=0: pc<=branch_addr, go DROP.
- imem_rvalid=1 and freeze=1: buffer imem_rdata, go HOLD.
- imem_rvalid=1 and freeze=0: deliver imem_rdata with address pc, pc<=pc+4. In the same cycle imem_req=1, imem_addr=pc+4; stay WAIT. This gives back-to-back throughput of 1 instruction/cycle with 1-cycle memory.
- otherwise: stay WAIT.

HOLD:
- branch_taken=1: discard buffer, pc<=branch_addr, go IDLE.
- freeze=0: deliver buffered instruction, pc<=pc+4, go IDLE.
- freeze=1: stay.

DROP:
- Wait for imem_rvalid, discard the data, go IDLE.
- A further branch_taken in DROP updates pc to the new branch_addr; stay DROP.

IF/ID register update, priority order:
1. branch_taken=1: if_id_valid<=0, if_id_inst<=0, if_id_pc<=0 (flush beats freeze).
2. freeze=1: hold all three.
3. deliver: if_id_inst<=instruction, if_id_pc<=its address+4, if_id_valid<=1.
4. otherwise: bubble (valid/inst/pc <= 0).

Invariants and edge cases:
- Never more than one outstanding request.
- No instruction is ever delivered twice or dropped without a branch.
- pc arithmetic wraps modulo 2^ADDR_W.
- imem_rvalid outside WAIT/DROP is illegal; it is ignored and the bench flags it.
- Reset mid-fetch returns to IDLE. A memory response that arrives after reset release for a pre-reset request is a system-level reset requirement on the memory, not handled here.

Test Plan:
- Reset then free-run, 1-cycle memory returning addr as data: imem_addr 0,4,8,12 on consecutive cycles after the first; if_id_inst=0,4,8 with if_id_pc=4,8,12; if_id_valid=1 from cycle 2.
- freeze=1 for 3 cycles while rvalid returns inst at 0x10: IF/ID unchanged during freeze, state HOLD, no imem_req. On release, if_id_inst=0x10, if_id_pc=0x14, next imem_addr=0x14.
- 3-cycle-latency memory, branch_taken with branch_addr=0x100 one cycle after request to 0x20: IF/ID flushed to valid=0. Late response for 0x20 is discarded. Next imem_addr=0x100; first delivered if_id_pc=0x104.
- branch_taken and freeze both high with IF/ID valid: if_id_valid=0 next cycle (flush wins); fetch resumes at branch_addr.
- pc=0xFFFFFFFC free-run: next imem_addr=0x00000000, if_id_pc=0x00000000 for that instruction.
- Assert rst low mid-WAIT: all outputs 0 immediately (asynchronous). After release, first imem_addr=RESET_PC.
